alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that feeds a shared single-cycle ALU into a one-entry
// output register. The result is presented one cycle after a request is accepted.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*3-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_left,
  input  logic [NUM_REQ*WIDTH-1:0] req_right,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [IdW-1:0]           out_id
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d, id_q, grant_idx;
  logic [WIDTH-1:0]  data_q, alu_result, opa, opb;
  logic [2:0]        op;
  logic [WIDTH+31:0] shamt_ext;
  logic              shamt_big, grant_found, can_load, transfer;
  int unsigned       cand, sel;

  // First valid requester at or after ptr, searching cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IdW'(cand);
      end
    end
  end

  // Reset is folded in so req_ready stays low for the whole reset window.
  assign can_load = reset && ((state_q == StEmpty) || out_ready);
  assign transfer = can_load && grant_found;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel = 32'(grant_idx);
    op  = req_op[sel*3 +: 3];
    opa = req_left[sel*WIDTH +: WIDTH];
    opb = req_right[sel*WIDTH +: WIDTH];
  end

  assign shamt_ext = {32'b0, opb};
  assign shamt_big = shamt_ext >= (WIDTH+32)'(WIDTH);

  always_comb begin
    alu_result = '0;
    unique case (op)
      3'd0: alu_result = opa + opb;
      3'd1: alu_result = opa - opb;
      3'd2: alu_result = opa * opb;
      3'd3: alu_result = opa & opb;
      3'd4: alu_result = opa | opb;
      3'd5: alu_result = opa ^ opb;
      3'd6: alu_result = shamt_big ? '0 : (opa << opb);
      3'd7: alu_result = shamt_big ? '0 : (opa >> opb);
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (transfer) begin
      state_d = StFull;
      ptr_d   = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (transfer) begin
        data_q <= alu_result;
        id_q   <= grant_idx;
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode table plus fairness, backpressure,
// pointer wrap and mid-operation reset sequences.
module tb_alu_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*3-1:0] req_op;
  logic [N*W-1:0] req_left, req_right;
  logic [N-1:0]   req_ready;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_left  (req_left),
    .req_right (req_right),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] l,
                         input logic [31:0] r);
    req_op[i*3 +: 3]    = op;
    req_left[i*W +: W]  = l;
    req_right[i*W +: W] = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    out_ready = 1'b1;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    req_valid = '0;
    req_op    = '0;
    req_left  = '0;
    req_right = '0;
    out_ready = 1'b1;
    reset     = 1'b0;

    vecs[0]  = '{2, 3'd0, 32'd5,          32'd7,        32'd12};
    vecs[1]  = '{0, 3'd1, 32'd0,          32'd1,        32'hFFFF_FFFF};
    vecs[2]  = '{1, 3'd2, 32'h0001_0000,  32'h0001_0000, 32'd0};
    vecs[3]  = '{3, 3'd6, 32'd1,          32'd32,       32'd0};
    vecs[4]  = '{2, 3'd7, 32'h8000_0000,  32'd31,       32'd1};
    vecs[5]  = '{0, 3'd2, 32'd3,          32'd7,        32'd21};
    vecs[6]  = '{1, 3'd3, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000};
    vecs[7]  = '{3, 3'd4, 32'h0000_F0F0,  32'h0000_0F0F, 32'h0000_FFFF};
    vecs[8]  = '{2, 3'd5, 32'hFFFF_0000,  32'hFF00_FF00, 32'h00FF_FF00};
    vecs[9]  = '{0, 3'd6, 32'd1,          32'd4,        32'd16};
    vecs[10] = '{1, 3'd7, 32'hFFFF_FFFF,  32'd100,      32'd0};
    vecs[11] = '{3, 3'd1, 32'd10,         32'd3,        32'd7};
    vecs[12] = '{2, 3'd0, 32'hFFFF_FFFF,  32'd2,        32'd1};
    vecs[13] = '{1, 3'd6, 32'h0000_0003,  32'd31,       32'h8000_0000};

    // Reset state
    #2;
    req_valid = 4'b1111;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_id", 64'(out_id), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    do_reset();

    // Opcode table, one lone requester each
    for (int v = 0; v < 14; v++) begin
      set_req(vecs[v].id, vecs[v].op, vecs[v].left, vecs[v].right);
      req_valid = 4'(1 << vecs[v].id);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(1 << vecs[v].id));
      tick();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", v), 64'(out_data), 64'(vecs[v].exp));
      chk($sformatf("vec%0d_id", v), 64'(out_id), 64'(vecs[v].id));
      tick();
    end
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Fairness: all valid, one result per cycle in order 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'd0, 32'(i * 10), 32'd1);
    req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk($sformatf("fair%0d_valid", c), 64'(out_valid), 64'd1);
        chk($sformatf("fair%0d_id", c), 64'(out_id), 64'((c - 1) % 4));
        chk($sformatf("fair%0d_data", c), 64'(out_data), 64'(((c - 1) % 4) * 10 + 1));
      end
      chk($sformatf("fair%0d_ready", c), 64'(req_ready), 64'(1 << (c % 4)));
      tick();
    end
    req_valid = '0;

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    set_req(0, 3'd0, 32'd1, 32'd1);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_first_ready", 64'(req_ready), 64'b0001);
    tick();
    set_req(1, 3'd0, 32'd40, 32'd2);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
      chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_data", c), 64'(out_data), 64'd2);
      chk($sformatf("bp%0d_id", c), 64'(out_id), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("bp_result_valid", 64'(out_valid), 64'd1);
    chk("bp_result_data", 64'(out_data), 64'd42);
    chk("bp_result_id", 64'(out_id), 64'd1);
    tick();

    // Wrap: advance ptr to 3, then requesters 0 and 3 valid -> 3 then 0
    set_req(2, 3'd0, 32'd0, 32'd0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("wrap_pre_ready", 64'(req_ready), 64'b0100);
    tick();
    set_req(3, 3'd4, 32'h30, 32'h3);
    set_req(0, 3'd5, 32'hFF, 32'h0F);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("wrap_first_ready", 64'(req_ready), 64'b1000);
    tick();
    @(negedge clk);
    chk("wrap_second_ready", 64'(req_ready), 64'b0001);
    chk("wrap_first_id", 64'(out_id), 64'd3);
    chk("wrap_first_data", 64'(out_data), 64'h33);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_second_id", 64'(out_id), 64'd0);
    chk("wrap_second_data", 64'(out_data), 64'hF0);
    tick();

    // Mid-operation reset discards a held result
    out_ready = 1'b0;
    set_req(1, 3'd0, 32'd7, 32'd8);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0110;
    @(negedge clk);
    chk("mr_full_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("mr_valid_async", 64'(out_valid), 64'd0);
    chk("mr_data_async", 64'(out_data), 64'd0);
    chk("mr_ready_async", 64'(req_ready), 64'd0);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mr_after_valid", 64'(out_valid), 64'd0);
    chk("mr_after_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("mr_after_id", 64'(out_id), 64'd1);
    chk("mr_after_data", 64'(out_data), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
